icache_assoc: RTL and testbench

// Parametrised N-way set-associative instruction cache between CPU fetch and instruction memory.

---
 rtl/icache_assoc.sv | 151 +++++++++++++++
 tb/tb_icache_assoc.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// N-way set-associative, read-only instruction cache with per-set round-robin
// replacement, deferred flush and saturating hit/miss counters.
module icache_assoc #(
  parameter int ADDR_W    = 10,
  parameter int WORD_W    = 32,
  parameter int BLK_WORDS = 4,
  parameter int SETS      = 8,
  parameter int WAYS      = 2,
  parameter int CNT_W     = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [ADDR_W-1:0]                 i_pc,
  input  logic                              flush,
  output logic [WORD_W-1:0]                 instruction,
  output logic                              i_busywait,
  output logic                              imem_read,
  output logic [ADDR_W-3-$clog2(BLK_WORDS):0] imem_pc,
  input  logic [BLK_WORDS*WORD_W-1:0]       imem_readdata,
  input  logic                              imem_busywait,
  output logic [CNT_W-1:0]                  hit_count,
  output logic [CNT_W-1:0]                  miss_count
);

  localparam int OFF_W = $clog2(BLK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int BA_W  = TAG_W + IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, MEM_READ, REFILL} state_t;
  typedef logic [BLK_WORDS-1:0][WORD_W-1:0] block_t;

  state_t state, state_next;

  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  block_t           data_mem [SETS][WAYS];
  logic [WAYS-1:0]  valid    [SETS];
  logic [WAY_W-1:0] rr       [SETS];

  logic [BA_W-1:0]  miss_addr;
  block_t           fill_data;
  logic             flush_pending;

  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] pc_idx;
  logic [OFF_W-1:0] pc_off;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             victim_by_rr;
  logic [WAY_W-1:0] rr_adv;
  logic             miss_take;
  logic             unused_pc_lsbs;

  assign pc_tag         = i_pc[ADDR_W-1 -: TAG_W];
  assign pc_idx         = i_pc[2+OFF_W +: IDX_W];
  assign pc_off         = i_pc[2 +: OFF_W];
  assign unused_pc_lsbs = ^i_pc[1:0];
  assign fill_tag       = miss_addr[BA_W-1 -: TAG_W];
  assign fill_idx       = miss_addr[IDX_W-1:0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[pc_idx][w] && tag_mem[pc_idx][w] == pc_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; only a full set falls back to the RR pointer.
  always_comb begin
    victim       = rr[fill_idx];
    victim_by_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[fill_idx][w]) begin
        victim       = WAY_W'(w);
        victim_by_rr = 1'b0;
      end
    end
  end

  assign rr_adv      = (rr[fill_idx] == WAY_W'(WAYS - 1)) ? '0 : rr[fill_idx] + 1'b1;
  assign instruction = hit ? data_mem[pc_idx][hit_way][pc_off] : '0;
  assign i_busywait  = (state != IDLE) | !hit | flush_pending;
  assign miss_take   = (state == IDLE) && !hit && !flush_pending && !flush;
  assign imem_read   = (state == MEM_READ);
  assign imem_pc     = imem_read ? miss_addr : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (miss_take) state_next = MEM_READ;
      MEM_READ: if (!imem_busywait) state_next = REFILL;
      REFILL:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      miss_addr     <= '0;
      flush_pending <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      state <= state_next;
      if (miss_take) begin
        miss_addr <= {pc_tag, pc_idx};
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
      if (!i_busywait && hit_count != '1) hit_count <= hit_count + 1'b1;
      if (state == IDLE) begin
        if (flush || flush_pending) begin
          flush_pending <= 1'b0;
          for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            rr[s]    <= '0;
          end
        end
      end else if (flush) begin
        flush_pending <= 1'b1;
      end
      if (state == REFILL) begin
        valid[fill_idx][victim] <= 1'b1;
        if (victim_by_rr) rr[fill_idx] <= rr_adv;
      end
    end
  end

  // NOTE: tag/data storage has no reset; the valid bits gate every read of it.
  always_ff @(posedge clock) begin
    if (state == MEM_READ && !imem_busywait) fill_data <= imem_readdata;
    if (state == REFILL) begin
      tag_mem[fill_idx][victim]  <= fill_tag;
      data_mem[fill_idx][victim] <= fill_data;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: a line-address cache model predicts hit/miss,
// data and counters; a negedge monitor pops expectations as fetches complete.
module tb_icache_assoc;

  localparam int ADDR_W = 10, WORD_W = 32, BLK_WORDS = 4, SETS = 8, WAYS = 2;
  localparam int BA_W = 6, BLK_W = 128;

  typedef struct packed {
    logic [BA_W-1:0]   ba;
    logic [WORD_W-1:0] word;
    logic              hit;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] i_pc;
  logic              flush;
  logic [WORD_W-1:0] instruction, sat_instruction;
  logic              i_busywait, sat_busywait;
  logic              imem_read, sat_imem_read;
  logic [BA_W-1:0]   imem_pc, sat_imem_pc;
  logic [BLK_W-1:0]  imem_readdata;
  logic              imem_busywait;
  logic [15:0]       hit_count, miss_count;
  logic [3:0]        sat_hit_count, sat_miss_count;

  icache_assoc dut (
    .clock(clock), .reset(reset), .i_pc(i_pc), .flush(flush),
    .instruction(instruction), .i_busywait(i_busywait),
    .imem_read(imem_read), .imem_pc(imem_pc),
    .imem_readdata(imem_readdata), .imem_busywait(imem_busywait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  icache_assoc #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .i_pc(i_pc), .flush(flush),
    .instruction(sat_instruction), .i_busywait(sat_busywait),
    .imem_read(sat_imem_read), .imem_pc(sat_imem_pc),
    .imem_readdata(imem_readdata), .imem_busywait(imem_busywait),
    .hit_count(sat_hit_count), .miss_count(sat_miss_count)
  );

  always #5 clock = ~clock;

  int   pass_cnt = 0, total_cnt = 0;
  int   line_ba [SETS][WAYS];
  int   rr_ptr  [SETS];
  int   exp_hits = 0, exp_misses = 0;
  exp_t q[$];
  bit   active = 0, got = 0, saw_read = 0, late_ack = 0;
  int   fixed_lat = 3;
  logic [ADDR_W-1:0] last_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [WORD_W-1:0] mem_word(input int ba, input int w);
    return (32'h11111111 * 32'(w)) ^ (32'(ba) * 32'h9E3779B1);
  endfunction

  function automatic logic [BLK_W-1:0] make_block(input int ba);
    logic [BLK_W-1:0] b;
    for (int w = 0; w < BLK_WORDS; w++) b[w*WORD_W +: WORD_W] = mem_word(ba, w);
    return b;
  endfunction

  // Reference model: each set holds up to WAYS block addresses (-1 = empty).
  function automatic bit model_hit(input int ba);
    for (int w = 0; w < WAYS; w++) if (line_ba[ba % SETS][w] == ba) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_fill(input int ba);
    int set = ba % SETS;
    int v = -1;
    for (int w = 0; w < WAYS; w++) if (v < 0 && line_ba[set][w] < 0) v = w;
    if (v < 0) begin
      v = rr_ptr[set];
      rr_ptr[set] = (rr_ptr[set] + 1) % WAYS;
    end
    line_ba[set][v] = ba;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      rr_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) line_ba[s][w] = -1;
    end
  endfunction

  task automatic check_counts();
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
    check("sat_hit_count", sat_hit_count, (exp_hits > 15) ? 15 : exp_hits);
    check("sat_miss_count", sat_miss_count, (exp_misses > 15) ? 15 : exp_misses);
  endtask

  // Memory responder: latency re-armed whenever no read is outstanding.
  int wait_left = 0;
  initial begin
    imem_busywait = 1'b1;
    imem_readdata = '0;
    forever begin
      @(negedge clock);
      if (late_ack) begin
        imem_busywait = 1'b0;
        imem_readdata = {4{32'hDEADBEEF}};
        wait_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end else if (imem_read) begin
        if (wait_left > 0) begin
          imem_busywait = 1'b1;
          wait_left--;
        end else begin
          imem_busywait = 1'b0;
          imem_readdata = make_block(int'(imem_pc));
        end
      end else begin
        imem_busywait = 1'b1;
        wait_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
    end
  end

  // Monitor: a fetch completes on the first negedge with i_busywait low.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (active) begin
        if (imem_read && !saw_read) begin
          saw_read = 1'b1;
          if (q.size() > 0) check("imem_pc", imem_pc, q[0].ba);
        end
        if (!i_busywait) begin
          if (q.size() == 0) begin
            total_cnt++;
            $display("FAIL scoreboard: response with empty queue at %0t", $time);
          end else begin
            e = q.pop_front();
            check("instruction", instruction, e.word);
            check("hit_flag", !saw_read, e.hit);
          end
          active = 1'b0;
          got    = 1'b1;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the completing hit edge.
  task automatic fetch(input logic [ADDR_W-1:0] pc, input bit flush_mid, output int n);
    int   ba;
    bit   hit;
    exp_t e;
    ba  = int'(pc) >> 4;
    hit = model_hit(ba);
    if (!hit) begin
      exp_misses++;
      model_fill(ba);
      if (flush_mid) begin
        model_clear();
        exp_misses++;
        model_fill(ba);
      end
    end
    exp_hits++;
    e.ba   = BA_W'(ba);
    e.word = mem_word(ba, (int'(pc) >> 2) & 3);
    e.hit  = hit;
    q.push_back(e);
    saw_read = 1'b0;
    got      = 1'b0;
    active   = 1'b1;
    i_pc     = pc;
    last_pc  = pc;
    n = 0;
    if (flush_mid && !hit) begin
      int k;
      k = 0;
      do begin @(negedge clock); k++; end while (!imem_read && k < 50);
      @(posedge clock); #1 flush = 1'b1;
      @(posedge clock); #1 flush = 1'b0;
    end
    while (!got && n < 300) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (!got) begin
      total_cnt++;
      $display("FAIL fetch_timeout: pc %0h never completed", pc);
      active = 1'b0;
      q.delete();
    end
    check_counts();
    if (hit) check("hit_latency", n, 1);
  endtask

  task automatic flush_idle();
    flush = 1'b1;
    if (model_hit(int'(last_pc) >> 4)) exp_hits++;
    @(posedge clock);
    #1 flush = 1'b0;
    model_clear();
    check_counts();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [ADDR_W-1:0] pc, old_pc;
    logic [ADDR_W-1:0] t2 [8] = '{10'h000, 10'h080, 10'h000, 10'h080, 10'h100, 10'h000, 10'h100, 10'h080};
    logic [ADDR_W-1:0] t6 [5] = '{10'h0B0, 10'h130, 10'h1B0, 10'h130, 10'h0B0};

    reset = 1'b0; flush = 1'b0; i_pc = '0; last_pc = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check("rst_imem_read", imem_read, 1'b0);
    check("rst_imem_pc", imem_pc, 0);
    check("rst_busywait", i_busywait, 1'b1);
    check("rst_instruction", instruction, 0);
    check_counts();

    // Cold miss with a fixed 3-cycle memory, then a same-block hit.
    reset = 1'b1;
    fetch(10'h000, 1'b0, n);
    check("miss_latency", n, 7);
    fetch(10'h008, 1'b0, n);

    // Conflicts in set 0 with round-robin eviction.
    foreach (t2[i]) fetch(t2[i], 1'b0, n);

    // Flush during a fill: fill completes, line is dropped, same pc misses again.
    fetch(10'h240, 1'b1, n);
    fetch(10'h244, 1'b0, n);

    // Invalid ways are filled first after a flush.
    flush_idle();
    fetch(10'h030, 1'b0, n);
    flush_idle();
    foreach (t6[i]) fetch(t6[i], 1'b0, n);

    // Randomised traffic over 24 blocks (3 per set) with occasional flushes.
    fixed_lat = -1;
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 99) < 5) flush_idle();
      pc = ADDR_W'($urandom_range(0, 23) * 16 + $urandom_range(0, 3) * 4);
      fetch(pc, ($urandom_range(0, 99) < 6), n);
    end

    // Reset in the middle of MEM_READ; a late memory ack must be ignored.
    fixed_lat = 3;
    old_pc = last_pc;
    i_pc = 10'h280;
    n = 0;
    do begin @(negedge clock); n++; end while (!imem_read && n < 20);
    check("pre_reset_imem_read", imem_read, 1'b1);
    #2 reset = 1'b0;
    late_ack = 1'b1;
    #1;
    check("async_imem_read", imem_read, 1'b0);
    check("async_imem_pc", imem_pc, 0);
    check("async_busywait", i_busywait, 1'b1);
    exp_hits = 0; exp_misses = 0;
    model_clear();
    check_counts();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    late_ack = 1'b0;
    fetch(10'h280, 1'b0, n);
    check("post_reset_latency", n, 7);
    fetch(old_pc, 1'b0, n);

    // Hold a resident pc: one hit per cycle, narrow counter saturates at 15.
    repeat (20) @(posedge clock);
    #1;
    exp_hits += 20;
    check_counts();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
